prog_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the program memory: owns the program counter, drives memory addr,

---
 rtl/prog_fetch_ctrl_pkg.sv | 20 ++
 rtl/prog_fetch_ctrl_if.sv | 27 ++
 rtl/prog_fetch_ctrl_fetch_buffer.sv | 72 +++++++
 rtl/prog_fetch_ctrl.sv | 105 ++++++++++
 tb/tb_prog_fetch_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/prog_fetch_ctrl_pkg.sv
// Shared types for the program fetch sequencer: FSM states, buffer depth, issue-credit helper.
`timescale 1ns/1ps
package prog_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   localparam int FIFO_DEPTH = 2;

   // A new read may only issue if it still fits once everything already committed lands.
   function automatic logic credit_ok(input logic [1:0] count, input logic inflight,
                                      input logic pop);
      return (3'(count) + 3'(inflight) - 3'(pop)) < 3'(FIFO_DEPTH);
   endfunction

endpackage

// File: rtl/prog_fetch_ctrl_if.sv
// Program-memory and decoder-side bus of the fetch sequencer.
`timescale 1ns/1ps
interface prog_fetch_ctrl_if #(
   parameter int WIDTH        = 5,
   parameter int ADDRESSWIDTH = 32
);
   logic                    run;
   logic [ADDRESSWIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]        mem_data;
   logic [WIDTH-1:0]        instr;
   logic [ADDRESSWIDTH-1:0] instr_pc;
   logic                    instr_valid;
   logic                    instr_ready;
   logic                    jump_en;
   logic [ADDRESSWIDTH-1:0] jump_target;
   logic                    halted;

   modport master (
      input  run, mem_data, instr_ready, jump_en, jump_target,
      output mem_addr, instr, instr_pc, instr_valid, halted
   );

   modport slave (
      output run, mem_data, instr_ready, jump_en, jump_target,
      input  mem_addr, instr, instr_pc, instr_valid, halted
   );
endinterface

// File: rtl/prog_fetch_ctrl_fetch_buffer.sv
// Two-entry FIFO of {pc, instr}; head entry is held in registers and drives the decoder directly.
`timescale 1ns/1ps
module prog_fetch_ctrl_fetch_buffer
   import prog_fetch_ctrl_pkg::*;
#(
   parameter int WIDTH        = 5,
   parameter int ADDRESSWIDTH = 32
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_push,
   input  logic [WIDTH-1:0]        i_instr,
   input  logic [ADDRESSWIDTH-1:0] i_pc,
   input  logic                    i_pop,
   input  logic                    i_flush,
   output logic [WIDTH-1:0]        o_instr,
   output logic [ADDRESSWIDTH-1:0] o_pc,
   output logic                    o_valid,
   output logic [1:0]              o_count
);
   logic [WIDTH-1:0]        r_head_instr, r_tail_instr;
   logic [ADDRESSWIDTH-1:0] r_head_pc, r_tail_pc;
   logic [1:0]              r_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_head_instr <= '0;
         r_head_pc    <= '0;
         r_tail_instr <= '0;
         r_tail_pc    <= '0;
         r_count      <= '0;
      end else if (i_flush) begin
         r_count <= '0;
      end else begin
         unique case ({i_push, i_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_head_instr <= i_instr;
                  r_head_pc    <= i_pc;
               end else begin
                  r_tail_instr <= i_instr;
                  r_tail_pc    <= i_pc;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head_instr <= r_tail_instr;
               r_head_pc    <= r_tail_pc;
               r_count      <= r_count - 2'd1;
            end
            2'b11: begin
               // count unchanged; the new entry lands wherever the popped slot frees up
               if (r_count == 2'd1) begin
                  r_head_instr <= i_instr;
                  r_head_pc    <= i_pc;
               end else begin
                  r_head_instr <= r_tail_instr;
                  r_head_pc    <= r_tail_pc;
                  r_tail_instr <= i_instr;
                  r_tail_pc    <= i_pc;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_instr = r_head_instr;
   assign o_pc    = r_head_pc;
   assign o_valid = (r_count != 2'd0);
   assign o_count = r_count;
endmodule

// File: rtl/prog_fetch_ctrl.sv
// Program fetch sequencer: FSM, fetch pointer, in-flight tracking and issue credit.
// Optional stall counter port o_stall_cycles when PROG_FETCH_PERF_EN is defined.
`timescale 1ns/1ps
module prog_fetch_ctrl
   import prog_fetch_ctrl_pkg::*;
#(
   parameter int WIDTH        = 5,
   parameter int ADDRESSWIDTH = 32,
   parameter int PROG_LEN     = 1024
) (
   input  logic               i_clk,
   input  logic               i_reset,
   prog_fetch_ctrl_if.master  bus
`ifdef PROG_FETCH_PERF_EN
   ,
   output logic [31:0]        o_stall_cycles
`endif
);
   localparam logic [ADDRESSWIDTH-1:0] LP_END = ADDRESSWIDTH'(PROG_LEN);

   fetch_state_e            r_state, w_state_nxt;
   logic [ADDRESSWIDTH-1:0] r_fpc, r_inflight_pc;
   logic                    r_inflight;
   logic [1:0]              w_count;
   logic                    w_valid, w_pop, w_jump, w_issue, w_at_end;

   assign w_pop    = w_valid & bus.instr_ready;
   assign w_at_end = (r_fpc >= LP_END);

   always_comb begin
      w_state_nxt = r_state;
      w_jump      = 1'b0;
      w_issue     = 1'b0;
      unique case (r_state)
         ST_IDLE: if (bus.run) w_state_nxt = ST_RUN;
         ST_RUN: begin
            w_jump  = bus.jump_en;
            w_issue = bus.run & ~w_at_end & ~bus.jump_en & credit_ok(w_count, r_inflight, w_pop);
            if (bus.jump_en)  w_state_nxt = ST_RUN;
            else if (w_at_end) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_jump = bus.jump_en;
            if (bus.jump_en) w_state_nxt = ST_RUN;
            else if (w_count == 2'd0 && !r_inflight) w_state_nxt = ST_HALT;
         end
         ST_HALT: ;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_fpc         <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (w_jump) begin
         r_fpc      <= bus.jump_target;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_fpc;
            r_fpc         <= r_fpc + ADDRESSWIDTH'(1);
         end
      end
   end

   // Memory returns data for last cycle's address, so an in-flight read pushes now.
   prog_fetch_ctrl_fetch_buffer #(
      .WIDTH        (WIDTH),
      .ADDRESSWIDTH (ADDRESSWIDTH)
   ) u_buf (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (r_inflight),
      .i_instr (bus.mem_data),
      .i_pc    (r_inflight_pc),
      .i_pop   (w_pop),
      .i_flush (w_jump),
      .o_instr (bus.instr),
      .o_pc    (bus.instr_pc),
      .o_valid (w_valid),
      .o_count (w_count)
   );

   assign bus.instr_valid = w_valid;
   assign bus.mem_addr    = r_fpc;
   assign bus.halted      = (r_state == ST_HALT);

`ifdef PROG_FETCH_PERF_EN
   logic [31:0] r_stall_cycles;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_stall_cycles <= '0;
      else if (w_valid && !bus.instr_ready && r_stall_cycles != 32'hFFFF_FFFF)
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end
   assign o_stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// Scoreboard bench for prog_fetch_ctrl with a 1-cycle registered program memory (mem[i]=i[4:0]).
`timescale 1ns/1ps
module tb_prog_fetch_ctrl;
   localparam int W  = 5;
   localparam int AW = 32;
   localparam int PL = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   q[$];
   int   mon_exp;

   prog_fetch_ctrl_if #(.WIDTH(W), .ADDRESSWIDTH(AW)) bus();
`ifdef PROG_FETCH_PERF_EN
   logic [31:0] stall;
`endif

   prog_fetch_ctrl #(.WIDTH(W), .ADDRESSWIDTH(AW), .PROG_LEN(PL)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.master)
`ifdef PROG_FETCH_PERF_EN
      ,
      .o_stall_cycles (stall)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) bus.mem_data <= bus.mem_addr[4:0];

   // Monitor: every accepted instruction must be the next expected pc in order.
   always @(negedge clk) begin
      if (!rst && bus.instr_valid && bus.instr_ready) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_instr: got pc %0d, expected no transfer", bus.instr_pc);
         end else begin
            mon_exp = q.pop_front();
            if (bus.instr_pc !== 32'(mon_exp) || bus.instr !== mon_exp[4:0]) begin
               n_err++;
               $display("FAIL seq: got pc %0d instr %0d, expected pc %0d instr %0d",
                        bus.instr_pc, bus.instr, mon_exp, mon_exp[4:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) q.push_back(i);
   endtask

   task automatic do_reset();
      bus.run = 1'b0; bus.instr_ready = 1'b0; bus.jump_en = 1'b0; bus.jump_target = '0;
      rst = 1'b1;
      q.delete();
      tick(); tick();
      rst = 1'b0;
      check("rst_valid", 32'(bus.instr_valid), 0);
      check("rst_halted", 32'(bus.halted), 0);
      check("rst_addr", bus.mem_addr, 0);
`ifdef PROG_FETCH_PERF_EN
      check("rst_stall", stall, 0);
`endif
   endtask

   task automatic wait_pc(input int p);
      int k = 0;
      while (!(bus.instr_valid && bus.instr_pc == 32'(p)) && k < 60) begin tick(); k++; end
      check("wait_pc", bus.instr_pc, 32'(p));
   endtask

   task automatic wait_halt();
      int k = 0;
      while (!bus.halted && k < 80) begin tick(); k++; end
      check("halted", 32'(bus.halted), 1);
      check("halt_valid", 32'(bus.instr_valid), 0);
      check("queue_empty", 32'(q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: async reset while an instruction is held
      do_reset();
      bus.run = 1'b1;
      tick(); tick(); tick();
      check("t1_valid_before", 32'(bus.instr_valid), 1);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check("t1_async_valid", 32'(bus.instr_valid), 0);
      check("t1_async_instr", 32'(bus.instr), 0);
      check("t1_async_pc", bus.instr_pc, 0);
      check("t1_async_addr", bus.mem_addr, 0);
      check("t1_async_halted", 32'(bus.halted), 0);

      // 2: full stream with ready high, latency and no gaps
      do_reset();
      push_range(0, 15);
      bus.instr_ready = 1'b1;
      bus.run = 1'b1;
      tick();
      tick();
      check("t2_lat_e1", 32'(bus.instr_valid), 0);
      tick();
      check("t2_lat_e2", 32'(bus.instr_valid), 1);
      check("t2_first_pc", bus.instr_pc, 0);
      for (int i = 1; i < PL; i++) begin
         tick();
         check("t2_stream_pc", {bus.instr_pc[30:0], bus.instr_valid}, 32'((i << 1) | 1));
      end
      wait_halt();

      // 3: backpressure for 5 cycles at start
      do_reset();
      push_range(0, 15);
      bus.run = 1'b1;
      tick(); tick(); tick();
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", 32'(bus.instr_valid), 1);
         check("t3_hold_pc", bus.instr_pc, 0);
         check("t3_no_overissue", bus.mem_addr, 2);
         tick();
      end
      bus.instr_ready = 1'b1;
      wait_halt();
`ifdef PROG_FETCH_PERF_EN
      check("t3_stall_cycles", stall, 5);
`endif

      // 4: jump at accept of pc 3 to 9
      do_reset();
      push_range(0, 3);
      push_range(9, 15);
      bus.instr_ready = 1'b1;
      bus.run = 1'b1;
      wait_pc(3);
      bus.jump_en = 1'b1; bus.jump_target = 32'd9;
      tick();
      bus.jump_en = 1'b0;
      check("t4_bubble0", 32'(bus.instr_valid), 0);
      tick();
      check("t4_bubble1", 32'(bus.instr_valid), 0);
      tick();
      check("t4_target_valid", 32'(bus.instr_valid), 1);
      check("t4_target_pc", bus.instr_pc, 9);
      wait_halt();

      // 5: jump beyond program end, then jump in HALT ignored
      do_reset();
      push_range(0, 2);
      bus.instr_ready = 1'b1;
      bus.run = 1'b1;
      wait_pc(2);
      bus.jump_en = 1'b1; bus.jump_target = 32'd20;
      tick();
      bus.jump_en = 1'b0;
      wait_halt();
      check("t5_addr", bus.mem_addr, 20);
      bus.jump_en = 1'b1; bus.jump_target = 32'd0;
      tick();
      bus.jump_en = 1'b0;
      tick(); tick(); tick();
      check("t5_halt_kept", 32'(bus.halted), 1);
      check("t5_halt_addr", bus.mem_addr, 20);
      check("t5_halt_valid", 32'(bus.instr_valid), 0);

      // 6: run paused for 3 cycles at pc 6
      do_reset();
      push_range(0, 15);
      bus.instr_ready = 1'b1;
      bus.run = 1'b1;
      wait_pc(6);
      bus.run = 1'b0;
      tick(); tick(); tick();
      check("t6_pause_addr", bus.mem_addr, 8);
      check("t6_pause_drained", 32'(bus.instr_valid), 0);
      bus.run = 1'b1;
      wait_halt();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
